// File: rtl/tick_rate_pkg.sv
// Shared types and elaboration-time helpers for the tick rate controller.
package tick_rate_pkg;

    typedef enum logic [0:0] {
        ST_RUN,
        ST_PAUSED
    } state_e;

    // Counter reload for rate index k; evaluated signed so a too-fast rate goes negative.
    function automatic int reload(input int clk_hz, input int base_hz, input int k);
        return clk_hz / (base_hz << k) - 1;
    endfunction

    function automatic int rate_w(input int num_rates);
        return (num_rates > 1) ? $clog2(num_rates) : 1;
    endfunction

endpackage

// File: rtl/tick_rate_ctrl_btn_edge_det.sv
// Rising-edge detector for a debounced, synchronous button; history resets to 1
// so a button held through reset does not fire.
module btn_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic edge_o
);

    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) prev_q <= 1'b1;
        else       prev_q <= btn_i;
    end

    assign edge_o = btn_i & ~prev_q;

endmodule

// File: rtl/tick_rate_ctrl.sv
// Run/pause/single-step and programmable-rate tick generator for the LFSR time base.
// Define TICK_RATE_CTRL_WRAP_EN to make the rate index wrap instead of saturate.
module tick_rate_ctrl
    import tick_rate_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BASE_HZ   = 1,
    parameter int NUM_RATES = 4,
    localparam int RATE_W   = rate_w(NUM_RATES)
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              btn_run,
    input  logic              btn_step,
    input  logic              btn_faster,
    input  logic              btn_slower,
    output logic              tick_en,
    output logic              clk_slow,
    output logic              running,
    output logic [RATE_W-1:0] rate_sel
);

    localparam int                CNT_W    = $clog2(reload(CLK_HZ, BASE_HZ, 0) + 1);
    localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(NUM_RATES - 1);

    if (reload(CLK_HZ, BASE_HZ, NUM_RATES - 1) < 1) begin : g_bad_cfg
        $error("tick_rate_ctrl: fastest rate needs a reload of at least 1");
    end

    logic run_e, step_e, fast_e, slow_e;

    btn_edge_det u_run  (.clk_i(clk_100MHz), .rst_i(reset), .btn_i(btn_run),    .edge_o(run_e));
    btn_edge_det u_step (.clk_i(clk_100MHz), .rst_i(reset), .btn_i(btn_step),   .edge_o(step_e));
    btn_edge_det u_fast (.clk_i(clk_100MHz), .rst_i(reset), .btn_i(btn_faster), .edge_o(fast_e));
    btn_edge_det u_slow (.clk_i(clk_100MHz), .rst_i(reset), .btn_i(btn_slower), .edge_o(slow_e));

    logic [CNT_W-1:0] reload_tab [NUM_RATES];

    for (genvar g = 0; g < NUM_RATES; g++) begin : g_reload
        assign reload_tab[g] = CNT_W'(reload(CLK_HZ, BASE_HZ, g));
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              tick_q, tick_d;
    logic              clk_slow_q, clk_slow_d;
    logic              rate_chg, wrap;

    always_comb begin
        rate_d = rate_q;
        if (fast_e && !slow_e) begin
            if (rate_q != RATE_MAX) rate_d = rate_q + RATE_W'(1);
`ifdef TICK_RATE_CTRL_WRAP_EN
            else                    rate_d = '0;
`endif
        end else if (slow_e && !fast_e) begin
            if (rate_q != '0) rate_d = rate_q - RATE_W'(1);
`ifdef TICK_RATE_CTRL_WRAP_EN
            else              rate_d = RATE_MAX;
`endif
        end
        rate_chg = (rate_d != rate_q);
        wrap     = (cnt_q == reload_tab[rate_q]);

        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A run edge wins over a wrap in the same cycle: the tick is dropped.
                if (run_e) begin
                    state_d = ST_PAUSED;
                    cnt_d   = '0;
                end else begin
                    tick_d = wrap;
                    cnt_d  = (wrap || rate_chg) ? '0 : cnt_q + CNT_W'(1);
                end
            end
            ST_PAUSED: begin
                cnt_d = '0;
                if (run_e) state_d = ST_RUN;
                else       tick_d  = step_e;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
        clk_slow_d = clk_slow_q ^ tick_d;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            rate_q     <= '0;
            tick_q     <= 1'b0;
            clk_slow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rate_q     <= rate_d;
            tick_q     <= tick_d;
            clk_slow_q <= clk_slow_d;
        end
    end

    assign tick_en  = tick_q;
    assign clk_slow = clk_slow_q;
    assign running  = (state_q == ST_RUN);
    assign rate_sel = rate_q;

endmodule
